sync_fifo_flags: RTL and testbench

- Single-clock successor to the dual-clock Gray-pointer FIFO; used where producer and consumer share one clock, so no pointer synchronisers.
- Generalised over width, depth and read mode, selectable first-word-fall-through (FWFT) or registered read.
- Adds behaviour the async FIFO lacks:
  - exact fill-level count;
  - programmable almost-full and almost-empty thresholds;
  - sticky overflow/underflow error flags;
  - synchronous flush.

---
 rtl/sync_fifo_flags.sv | 128 ++++++++++++
 tb/tb_sync_fifo_flags.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with exact fill count, programmable almost flags,
// sticky overflow/underflow and synchronous flush.
//
// Ports:
//   clk, rst_n     : clock, async active-low reset
//   wdata, winc    : write data and write request
//   rinc           : read request
//   flush          : synchronous clear of contents and error flags
//   rdata          : read data (FWFT=1 combinational, FWFT=0 registered)
//   wfull, rempty  : count == DEPTH / count == 0
//   walmost_full   : count >= AFULL_THRESH
//   ralmost_empty  : count <= AEMPTY_THRESH
//   count          : fill level 0..DEPTH
//   overflow       : sticky, write attempted while full
//   underflow      : sticky, read attempted while empty
module sync_fifo_flags #(
    parameter int DSIZE         = 80,
    parameter int ASIZE         = 6,
    parameter int AFULL_THRESH  = 60,
    parameter int AEMPTY_THRESH = 4,
    parameter bit FWFT          = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [DSIZE-1:0] wdata,
    input  logic             winc,
    input  logic             rinc,
    input  logic             flush,
    output logic [DSIZE-1:0] rdata,
    output logic             wfull,
    output logic             rempty,
    output logic             walmost_full,
    output logic             ralmost_empty,
    output logic [ASIZE:0]   count,
    output logic             overflow,
    output logic             underflow
);

    localparam int DEPTH = 2 ** ASIZE;

    localparam logic [ASIZE:0] DEPTH_C = {1'b1, {ASIZE{1'b0}}};
    localparam logic [ASIZE:0] AF_C    = (ASIZE+1)'(AFULL_THRESH);
    localparam logic [ASIZE:0] AE_C    = (ASIZE+1)'(AEMPTY_THRESH);

    logic [DSIZE-1:0] mem [DEPTH];

    logic [ASIZE:0]   wbin;
    logic [ASIZE:0]   rbin;
    logic [ASIZE-1:0] waddr;
    logic [ASIZE-1:0] raddr;
    logic             we;
    logic             re;

    assign waddr = wbin[ASIZE-1:0];
    assign raddr = rbin[ASIZE-1:0];

    // Flags come only from the registered count, so same-cycle
    // requests never ripple into them.
    assign wfull         = (count == DEPTH_C);
    assign rempty        = (count == '0);
    assign walmost_full  = (count >= AF_C);
    assign ralmost_empty = (count <= AE_C);

    // Flush wins over both requests.
    assign we = winc & ~wfull & ~flush;
    assign re = rinc & ~rempty & ~flush;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wbin      <= '0;
            rbin      <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (flush) begin
            wbin      <= '0;
            rbin      <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (we) begin
                wbin <= wbin + 1'b1;
            end
            if (re) begin
                rbin <= rbin + 1'b1;
            end
            unique case ({we, re})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (winc && wfull) begin
                overflow <= 1'b1;
            end
            if (rinc && rempty) begin
                underflow <= 1'b1;
            end
        end
    end

    generate
        if (FWFT) begin : g_fwft
            // Head word is always on the output while not empty.
            assign rdata = mem[raddr];
        end else begin : g_reg
            logic [DSIZE-1:0] rdata_q;

            // Flush leaves the output register untouched.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    rdata_q <= '0;
                end else if (re) begin
                    rdata_q <= mem[raddr];
                end
            end

            assign rdata = rdata_q;
        end
    endgenerate

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Directed bench for sync_fifo_flags: FWFT instance runs the fill,
// overflow, wrap and flush sequences; registered-read instance uses a table.
module tb_sync_fifo_flags;

    localparam int DW = 80;

    logic          clk;
    logic          rst_n;

    logic [DW-1:0] wdata;
    logic          winc;
    logic          rinc;
    logic          flush;
    logic [DW-1:0] rdata;
    logic          wfull;
    logic          rempty;
    logic          walmost_full;
    logic          ralmost_empty;
    logic [6:0]    count;
    logic          overflow;
    logic          underflow;

    logic [DW-1:0] wdata0;
    logic          winc0;
    logic          rinc0;
    logic          flush0;
    logic [DW-1:0] rdata0;
    logic          wfull0;
    logic          rempty0;
    logic          walmost_full0;
    logic          ralmost_empty0;
    logic [6:0]    count0;
    logic          overflow0;
    logic          underflow0;

    int total;
    int passed;

    sync_fifo_flags #(.FWFT(1'b1)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .wdata         (wdata),
        .winc          (winc),
        .rinc          (rinc),
        .flush         (flush),
        .rdata         (rdata),
        .wfull         (wfull),
        .rempty        (rempty),
        .walmost_full  (walmost_full),
        .ralmost_empty (ralmost_empty),
        .count         (count),
        .overflow      (overflow),
        .underflow     (underflow)
    );

    sync_fifo_flags #(.FWFT(1'b0)) dut0 (
        .clk           (clk),
        .rst_n         (rst_n),
        .wdata         (wdata0),
        .winc          (winc0),
        .rinc          (rinc0),
        .flush         (flush0),
        .rdata         (rdata0),
        .wfull         (wfull0),
        .rempty        (rempty0),
        .walmost_full  (walmost_full0),
        .ralmost_empty (ralmost_empty0),
        .count         (count0),
        .overflow      (overflow0),
        .underflow     (underflow0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [DW-1:0] act,
                       input logic [DW-1:0] exp);
        total++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic          w;
        logic          r;
        logic          f;
        logic [DW-1:0] d;
        logic [6:0]    exp_count;
        logic [DW-1:0] exp_rdata;
        logic          exp_uf;
    } vec_t;

    vec_t tv [9];

    initial begin
        int wr;
        int rd;
        int mc;
        logic w;
        logic r;

        total  = 0;
        passed = 0;

        tv[0] = '{1'b1, 1'b0, 1'b0, 80'h11, 7'd1, 80'h0,  1'b0};
        tv[1] = '{1'b1, 1'b0, 1'b0, 80'h22, 7'd2, 80'h0,  1'b0};
        tv[2] = '{1'b0, 1'b1, 1'b0, 80'h0,  7'd1, 80'h11, 1'b0};
        tv[3] = '{1'b0, 1'b1, 1'b0, 80'h0,  7'd0, 80'h22, 1'b0};
        tv[4] = '{1'b0, 1'b1, 1'b0, 80'h0,  7'd0, 80'h22, 1'b1};
        tv[5] = '{1'b1, 1'b1, 1'b1, 80'h99, 7'd0, 80'h22, 1'b0};
        tv[6] = '{1'b1, 1'b0, 1'b0, 80'h33, 7'd1, 80'h22, 1'b0};
        tv[7] = '{1'b1, 1'b1, 1'b0, 80'h44, 7'd1, 80'h33, 1'b0};
        tv[8] = '{1'b0, 1'b1, 1'b0, 80'h0,  7'd0, 80'h44, 1'b0};

        rst_n  = 1'b0;
        wdata  = '0;
        winc   = 1'b0;
        rinc   = 1'b0;
        flush  = 1'b0;
        wdata0 = '0;
        winc0  = 1'b0;
        rinc0  = 1'b0;
        flush0 = 1'b0;

        #12;
        chk("rst_count", 80'(count), 80'd0);
        chk("rst_rempty", 80'(rempty), 80'd1);
        chk("rst_raempty", 80'(ralmost_empty), 80'd1);
        chk("rst_wfull", 80'(wfull), 80'd0);
        chk("rst_wafull", 80'(walmost_full), 80'd0);
        chk("rst_ovf", 80'(overflow), 80'd0);
        chk("rst_udf", 80'(underflow), 80'd0);
        chk("rst_rdata0", rdata0, 80'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Fill 64 words, no reads.
        for (int i = 0; i < 64; i++) begin
            winc  = 1'b1;
            wdata = 80'(i);
            tick();
            chk("fill_count", 80'(count), 80'(i + 1));
            chk("fill_wafull", 80'(walmost_full), 80'(i + 1 >= 60));
            chk("fill_wfull", 80'(wfull), 80'(i + 1 == 64));
            chk("fill_raempty", 80'(ralmost_empty), 80'(i + 1 <= 4));
            chk("fill_head", rdata, 80'd0);
        end

        // Writes while full are dropped and flagged.
        for (int i = 0; i < 2; i++) begin
            winc  = 1'b1;
            wdata = 80'hAA;
            tick();
            chk("ovf_count", 80'(count), 80'd64);
            chk("ovf_flag", 80'(overflow), 80'd1);
        end
        winc = 1'b0;

        for (int i = 0; i < 64; i++) begin
            chk("drain_data", rdata, 80'(i));
            rinc = 1'b1;
            tick();
            chk("drain_count", 80'(count), 80'(63 - i));
        end
        rinc = 1'b0;
        chk("drain_rempty", 80'(rempty), 80'd1);
        chk("drain_ovf_sticky", 80'(overflow), 80'd1);
        chk("drain_udf", 80'(underflow), 80'd0);

        // Both requests while empty: only the write lands.
        winc  = 1'b1;
        rinc  = 1'b1;
        wdata = 80'd100;
        tick();
        chk("emp_both_count", 80'(count), 80'd1);
        chk("emp_both_udf", 80'(underflow), 80'd1);
        for (int k = 0; k < 10; k++) begin
            wdata = 80'(101 + k);
            chk("both_data", rdata, 80'(100 + k));
            tick();
            chk("both_count", 80'(count), 80'd1);
        end
        winc = 1'b0;
        chk("both_last", rdata, 80'd110);
        tick();
        rinc = 1'b0;
        chk("both_empty", 80'(count), 80'd0);

        // Interleaved traffic across the pointer wrap.
        wr = 0;
        rd = 0;
        mc = 0;
        for (int cyc = 0; cyc < 400 && rd < 100; cyc++) begin
            w = (wr < 100);
            r = (mc >= 10) || (wr >= 100 && mc > 0);
            if (r) begin
                chk("wrap_data", rdata, 80'(1000 + rd));
            end
            winc  = w;
            rinc  = r;
            wdata = 80'(1000 + wr);
            tick();
            if (w) begin
                wr++;
                mc++;
            end
            if (r) begin
                rd++;
                mc--;
            end
            chk("wrap_count", 80'(count), 80'(mc));
            chk("wrap_wfull", 80'(wfull), 80'd0);
        end
        winc = 1'b0;
        rinc = 1'b0;
        chk("wrap_all_read", 80'(rd), 80'd100);

        // Fill to 30 then flush with both requests.
        for (int i = 0; i < 30; i++) begin
            winc  = 1'b1;
            wdata = 80'(2000 + i);
            tick();
        end
        chk("pre_flush_count", 80'(count), 80'd30);
        flush = 1'b1;
        rinc  = 1'b1;
        wdata = 80'hBEEF;
        tick();
        flush = 1'b0;
        winc  = 1'b0;
        rinc  = 1'b0;
        chk("flush_count", 80'(count), 80'd0);
        chk("flush_rempty", 80'(rempty), 80'd1);
        chk("flush_ovf", 80'(overflow), 80'd0);
        chk("flush_udf", 80'(underflow), 80'd0);

        winc  = 1'b1;
        wdata = 80'h55;
        tick();
        winc = 1'b0;
        chk("post_flush_count", 80'(count), 80'd1);
        chk("post_flush_data", rdata, 80'h55);
        rinc = 1'b1;
        tick();
        tick();
        rinc = 1'b0;
        chk("post_flush_udf", 80'(underflow), 80'd1);

        // Async reset in the middle of a write burst.
        for (int i = 0; i < 5; i++) begin
            winc  = 1'b1;
            wdata = 80'(3000 + i);
            tick();
        end
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_count", 80'(count), 80'd0);
        chk("arst_rempty", 80'(rempty), 80'd1);
        chk("arst_udf", 80'(underflow), 80'd0);
        chk("arst_raempty", 80'(ralmost_empty), 80'd1);
        winc = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        winc  = 1'b1;
        wdata = 80'h77;
        tick();
        winc = 1'b0;
        chk("arst_wr_count", 80'(count), 80'd1);
        chk("arst_wr_data", rdata, 80'h77);

        // Registered-read instance, table driven.
        for (int i = 0; i < 9; i++) begin
            winc0  = tv[i].w;
            rinc0  = tv[i].r;
            flush0 = tv[i].f;
            wdata0 = tv[i].d;
            tick();
            chk($sformatf("reg_count[%0d]", i), 80'(count0), 80'(tv[i].exp_count));
            chk($sformatf("reg_rdata[%0d]", i), rdata0, tv[i].exp_rdata);
            chk($sformatf("reg_udf[%0d]", i), 80'(underflow0), 80'(tv[i].exp_uf));
        end
        winc0  = 1'b0;
        rinc0  = 1'b0;
        flush0 = 1'b0;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
